lin_batch_sequencer: RTL

- Hardware initiator for the linealizador Begin/ACK handshake.
- Reads N operand words from a sample memory and, per word, resets the core, loads T and pulses BEGIN_FSM.
- Waits for the ACK rising edge, then writes RESULT plus O_F/U_F flags to a result memory.
- Replaces the simulation-only stimulus loop, so normalisation/linearisation batches run on silicon with a per-sample timeout watchdog.

---
 rtl/lin_batch_sequencer_if.sv | 48 ++++
 rtl/lin_batch_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/lin_batch_sequencer_if.sv
// ----------------------------------------------------------------------------
// lin_batch_sequencer_if
// Bundles every non-clock signal of the batch sequencer: the batch control
// (start / length / status), the sample-memory read port, the core handshake
// (operand, core reset, begin pulse, ack, result and flags) and the
// result-memory write port.
//   master : the sequencer side
//   slave  : the environment side (memories + linealizador core + host)
// ----------------------------------------------------------------------------
interface lin_batch_sequencer_if #(
  parameter int P = 32,
  parameter int W = 10
);
  // Batch control / status
  logic           start;
  logic [W:0]     n_samples;
  logic           busy;
  logic           done;
  logic [W:0]     err_cnt;
  // Sample memory read port
  logic           rd_en;
  logic [W-1:0]   rd_addr;
  logic [P-1:0]   rd_data;
  // Core handshake
  logic [P-1:0]   t_out;
  logic           rst_core;
  logic           begin_fsm;
  logic           ack_in;
  logic [P-1:0]   result_in;
  logic           o_f_in;
  logic           u_f_in;
  // Result memory write port
  logic           wr_en;
  logic [W-1:0]   wr_addr;
  logic [P+2:0]   wr_data;

  modport master (
    input  start, n_samples, rd_data, ack_in, result_in, o_f_in, u_f_in,
    output busy, done, err_cnt, rd_en, rd_addr, t_out, rst_core, begin_fsm,
           wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, n_samples, rd_data, ack_in, result_in, o_f_in, u_f_in,
    input  busy, done, err_cnt, rd_en, rd_addr, t_out, rst_core, begin_fsm,
           wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/lin_batch_sequencer.sv
// ----------------------------------------------------------------------------
// lin_batch_sequencer
// Hardware initiator for the linealizador Begin/ACK handshake. For each of N
// samples it reads the operand from sample memory, resets the core, loads the
// operand, pulses BEGIN_FSM and waits for the rising edge of ACK. The result
// and flags ({TO, O_F, U_F, RESULT}) are written to result memory at the
// sample index. A per-sample watchdog turns a missing ACK into a TO=1 entry
// with zero data and bumps the error counter.
// Ports:
//   clk_i  : system clock
//   rst_i  : synchronous active-high reset (aborts a running batch)
//   bus    : lin_batch_sequencer_if.master (control, memories, core handshake)
// ----------------------------------------------------------------------------
module lin_batch_sequencer #(
  parameter int P       = 32,
  parameter int W       = 10,
  parameter int TIMEOUT = 2500
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  lin_batch_sequencer_if.master  bus
);

  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_ARM,
    S_PULSE,
    S_WAIT_ACK,
    S_STORE,
    S_FINISH
  } state_t;

  state_t         state_q, state_d;
  logic [W:0]     n_q, n_d;
  logic [W-1:0]   idx_q, idx_d;
  logic [WDW-1:0] wdog_q, wdog_d;
  logic           ack_q, ack_d;
  logic [P+2:0]   cap_q, cap_d;
  logic [P-1:0]   t_q, t_d;
  logic [W:0]     err_q, err_d;

  logic           ack_edge;
  logic           rd_en, rst_core, begin_fsm, wr_en, busy, done;

  // Only a fresh ACK counts; a level left high after capture is ignored
  // because ack_q follows it until the next core reset.
  assign ack_edge = bus.ack_in & ~ack_q;

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    idx_d     = idx_q;
    wdog_d    = wdog_q;
    ack_d     = bus.ack_in;
    cap_d     = cap_q;
    t_d       = t_q;
    err_d     = err_q;
    rd_en     = 1'b0;
    rst_core  = 1'b0;
    begin_fsm = 1'b0;
    wr_en     = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (bus.start) begin
          if (bus.n_samples != '0) begin
            n_d     = bus.n_samples;
            idx_d   = '0;
            err_d   = '0;
            state_d = S_FETCH;
          end else begin
            // Empty batch: just acknowledge with a DONE pulse.
            state_d = S_FINISH;
          end
        end
      end
      S_FETCH: begin
        rd_en   = 1'b1;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        // Memory data arrives one cycle after the read strobe.
        t_d      = bus.rd_data;
        rst_core = 1'b1;
        ack_d    = 1'b0;
        state_d  = S_ARM;
      end
      S_ARM: begin
        state_d = S_PULSE;
      end
      S_PULSE: begin
        begin_fsm = 1'b1;
        wdog_d    = '0;
        state_d   = S_WAIT_ACK;
      end
      S_WAIT_ACK: begin
        // The ACK edge is tested first so it wins over a simultaneous timeout.
        if (ack_edge) begin
          cap_d   = {1'b0, bus.o_f_in, bus.u_f_in, bus.result_in};
          state_d = S_STORE;
        end else if (wdog_q == WDOG_LAST) begin
          cap_d   = {1'b1, {(P+2){1'b0}}};
          err_d   = err_q + 1'b1;
          state_d = S_STORE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      S_STORE: begin
        wr_en = 1'b1;
        // Compare in W+1 bits so a full 2**W batch ends at index 2**W-1
        // without the index ever wrapping to address 0.
        if ({1'b0, idx_q} == n_q - 1'b1) begin
          state_d = S_FINISH;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FINISH: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      idx_q   <= '0;
      wdog_q  <= '0;
      ack_q   <= 1'b0;
      cap_q   <= '0;
      t_q     <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      wdog_q  <= wdog_d;
      ack_q   <= ack_d;
      cap_q   <= cap_d;
      t_q     <= t_d;
      err_q   <= err_d;
    end
  end

  // Addresses and write data are gated by their strobes so the buses sit at
  // zero whenever no transfer is in progress.
  assign bus.rd_en     = rd_en;
  assign bus.rd_addr   = rd_en ? idx_q : '0;
  assign bus.t_out     = t_q;
  assign bus.rst_core  = rst_core;
  assign bus.begin_fsm = begin_fsm;
  assign bus.wr_en     = wr_en;
  assign bus.wr_addr   = wr_en ? idx_q : '0;
  assign bus.wr_data   = wr_en ? cap_q : '0;
  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.err_cnt   = err_q;

endmodule
